seq_divider: RTL and testbench

Multi-cycle, parametrised integer divider that replaces the single-step DIV path feeding the Z register pair. Accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock using restoring radix-2 division. Supports signed or unsigned operation per request and flags divide-by-zero. Quotient is routed to ZLow/LO and remainder to ZHigh/HI by the datapath control sequence.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_twos_negate.sv | 13 +
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// the DIV ALU opcode used by the control sequence, and the default width.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/seq_divider_twos_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and for
// the final sign correction of quotient and remainder.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic             negate,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring radix-2 divider, one quotient bit per clock, with
// optional signed operation and divide-by-zero reporting.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] dvd_q, dvs_q;
    logic             sgn_q;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             q_neg, r_neg, dbz_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] dvd_abs, dvs_abs, quo_fix, rem_fix;
    logic [WIDTH:0]   shifted, trial;

    twos_negate #(.WIDTH(WIDTH)) u_neg_dvd (
        .negate (sgn_q & dvd_q[WIDTH-1]),
        .value  (dvd_q),
        .result (dvd_abs)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_dvs (
        .negate (sgn_q & dvs_q[WIDTH-1]),
        .value  (dvs_q),
        .result (dvs_abs)
    );

    twos_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .negate (q_neg),
        .value  (quo_q),
        .result (quo_fix)
    );

    twos_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .negate (r_neg & (|rem_q)),
        .value  (rem_q),
        .result (rem_fix)
    );

    // The partial remainder briefly needs one extra bit after the shift.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    // NOTE: every register here is updated with non-blocking assignments so all
    // of them see the pre-edge values of one another within the same clock.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state       <= ST_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            dvs_mag     <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz_q       <= 1'b0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        sgn_q <= is_signed & SIGNED_EN;
                        busy  <= 1'b1;
                        state <= ST_PREP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    quo_q   <= dvd_abs;
                    dvs_mag <= dvs_abs;
                    q_neg   <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg   <= sgn_q & dvd_q[WIDTH-1];
                    rem_q   <= '0;
                    cnt_q   <= CNT_W'(WIDTH - 1);
                    dbz_q   <= (dvs_q == '0);
                    // A zero divisor skips iteration; FIX emits the flagged result.
                    state   <= (dvs_q == '0) ? ST_FIX : ST_ITER;
                end
                ST_ITER: begin
                    quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    if (cnt_q == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (dbz_q) begin
                        quotient    <= '1;
                        remainder   <= dvd_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= quo_fix;
                        remainder   <= rem_fix;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a 32-bit instance for directed cases and
// reset behaviour, an 8-bit instance for randomized back-to-back traffic.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        longint      due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    exp_t sb32[$];
    exp_t sb8[$];

    logic        start32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;

    logic        start8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .Clock(clk), .Clear(rst_n), .start(start32), .is_signed(sg32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .Clock(clk), .Clear(rst_n), .start(start8), .is_signed(sg8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer / and % after sign interpretation at width w.
    function automatic exp_t model(int w, bit sgn, logic [31:0] a, logic [31:0] b);
        exp_t e;
        longint ax, bx, q, r;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        e.due = 0;
        if (b == 0) begin
            e.q = mask;
            e.r = a;
            e.dbz = 1'b1;
            return e;
        end
        ax = longint'(a);
        bx = longint'(b);
        if (sgn && a[w-1]) ax = ax - (longint'(1) << w);
        if (sgn && b[w-1]) bx = bx - (longint'(1) << w);
        q = ax / bx;
        r = ax % bx;
        e.q = 32'(q) & mask;
        e.r = 32'(r) & mask;
        e.dbz = 1'b0;
        return e;
    endfunction

    task automatic wait_idle32();
        int t = 0;
        while (busy32 && t < 200) begin @(negedge clk); t++; end
        if (busy32) check("idle_timeout32", {63'd0, busy32}, 64'd0);
    endtask

    task automatic issue32(bit sg, logic [31:0] a, logic [31:0] b, bit expect_result);
        exp_t e;
        wait_idle32();
        start32 = 1'b1; sg32 = sg; a32 = a; b32 = b;
        if (expect_result) begin
            e = model(32, sg, a, b);
            e.due = cyc + 1 + (e.dbz ? 2 : 34);
            sb32.push_back(e);
        end
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic drain32();
        int t = 0;
        while (sb32.size() != 0 && t < 100) begin @(negedge clk); t++; end
        check("drain32", 64'(sb32.size()), 64'd0);
        sb32.delete();
    endtask

    task automatic issue8(bit sg, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int t = 0;
        while (busy8 && t < 100) begin @(negedge clk); t++; end
        if (busy8) check("idle_timeout8", {63'd0, busy8}, 64'd0);
        start8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
        e = model(8, sg, {24'd0, a}, {24'd0, b});
        e.due = cyc + 1 + (e.dbz ? 2 : 10);
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done32) begin
            if (sb32.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done32: got done with q=%h r=%h, expected no done", q32, r32);
            end else begin
                exp_t e;
                e = sb32.pop_front();
                check("quotient32", 64'(q32), 64'(e.q));
                check("remainder32", 64'(r32), 64'(e.r));
                check("dbz32", 64'(dbz32), 64'(e.dbz));
                check("latency32", 64'(cyc), 64'(e.due));
                check("busy_low_at_done32", 64'(busy32), 64'd0);
            end
        end
        if (done8) begin
            if (sb8.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done8: got done with q=%h r=%h, expected no done", q8, r8);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                check("quotient8", 64'(q8), 64'(e.q[7:0]));
                check("remainder8", 64'(r8), 64'(e.r[7:0]));
                check("dbz8", 64'(dbz8), 64'(e.dbz));
                check("latency8", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint e0;
        repeat (3) @(negedge clk);
        check("reset_outputs32", {busy32, done32, dbz32, q32, r32}, 64'd0);
        check("reset_outputs8", {busy8, done8, dbz8, q8, r8}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue32(1'b0, 32'h0000_00A6, 32'h0000_0018, 1'b1); drain32();
        issue32(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1); drain32();
        issue32(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1); drain32();
        issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain32();
        issue32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain32();
        issue32(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1); drain32();
        issue32(1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1); drain32();

        // A start pulse with fresh operands while busy must be ignored.
        issue32(1'b0, 32'h0000_00A6, 32'h0000_0018, 1'b1);
        repeat (4) @(negedge clk);
        start32 = 1'b1; sg32 = 1'b1; a32 = 32'h1111_1111; b32 = 32'h0000_0003;
        @(negedge clk);
        start32 = 1'b0;
        drain32();

        issue32(1'b0, 32'h0000_1234, 32'h0000_0000, 1'b1); drain32();

        // Clear during the 10th ITER cycle; the request must vanish silently.
        e0 = cyc + 1;
        issue32(1'b0, 32'hDEAD_BEEF, 32'h0000_0013, 1'b0);
        while (cyc < e0 + 5) @(negedge clk);
        start32 = 1'b1; a32 = 32'h0000_0100; b32 = 32'h0000_0004;
        @(negedge clk);
        start32 = 1'b0;
        while (cyc < e0 + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("clear_busy32", 64'(busy32), 64'd0);
        check("clear_outputs32", {done32, dbz32, q32, r32}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue32(1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 1'b1); drain32();

        for (int i = 0; i < 200; i++) begin
            issue8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)));
        end
        begin
            int t = 0;
            while (sb8.size() != 0 && t < 100) begin @(negedge clk); t++; end
            check("drain8", 64'(sb8.size()), 64'd0);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
